fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the pipelined RISC CPU and the producer side of the decode stage's instruction input. Owns the PC and drives the instruction-memory read address. Delivers each instruction, together with its 16-bit immediate word when it has one, as a single registered fetch/decode bundle. Handles the boot vector, branch redirects, pipeline stalls and the interrupt vector.

## Interface

Parameters:
- RESET_VECTOR_ADDR, 16'h0000, imem address holding the boot PC
- INT_VECTOR_ADDR, 16'h0001, imem address holding the interrupt handler PC
- IMM_OPCODE, 3'b110, value of instr[15:13] marking a two-word (instruction + immediate) instruction

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - i_clk  in  1  clock; all state changes on the rising edge
  - i_reset_n  in  1  synchronous active-low reset
- Instruction memory:
  - o_imem_addr  out  16  instruction-memory word address (combinational)
  - i_imem_data  in  16  instruction-memory word, combinational read of o_imem_addr
- Control inputs:
  - i_stall  in  1  hold all state and outputs
  - i_branch_taken  in  1  redirect fetch to i_branch_target
  - i_branch_target  in  16  redirect PC
  - i_interrupt  in  1  interrupt request, pulse or level
- Bundle outputs (to decode):
  - o_instr  out  16  instruction word
  - o_imm  out  16  immediate word; valid only for IMM_OPCODE instructions
  - o_pc  out  16  address of o_instr, or the return address for an interrupt bundle
  - o_valid  out  1  bundle valid; low means bubble
  - o_interrupt  out  1  bundle is an interrupt pseudo-instruction

## Operation

- State machine: BOOT, RUN, IMM, INT.
- Reset, when i_reset_n is low at a rising edge:
  - state=BOOT, pc=0, pending_int=0.
  - o_instr, o_imm, o_pc = 0; o_valid, o_interrupt = 0.
- o_imem_addr by state:
  - BOOT: RESET_VECTOR_ADDR
  - INT: INT_VECTOR_ADDR
  - RUN, IMM: pc
- BOOT: pc <= i_imem_data; o_valid <= 0; go to RUN. Ignores i_stall, branch and interrupt.
- RUN, evaluated in priority order:
  1. Branch: pc <= i_branch_target; o_valid <= 0; stay in RUN.
  2. Stall: hold everything.
  3. pending_int set: o_valid <= 1, o_interrupt <= 1, o_instr <= 0, o_pc <= pc (first unexecuted address); go to INT. pc is not incremented.
  4. i_imem_data[15:13]==IMM_OPCODE: hold_instr <= i_imem_data, hold_pc <= pc, pc <= pc+1, o_valid <= 0; go to IMM.
  5. Otherwise: o_instr <= i_imem_data, o_pc <= pc, o_imm <= 0, o_valid <= 1, o_interrupt <= 0, pc <= pc+1.
- IMM:
  - Branch: pc <= target, o_valid <= 0, go to RUN. The held instruction is discarded.
  - Stall: hold everything.
  - Otherwise: o_instr <= hold_instr, o_imm <= i_imem_data, o_pc <= hold_pc, o_valid <= 1, pc <= pc+1; go to RUN.
  - A pending interrupt is serviced only after the pair completes, never between the two words.
- INT: pc <= i_imem_data; pending_int <= 0; o_valid <= 0, o_interrupt <= 0; go to RUN. Ignores stall and branch.
- pending_int:
  - Set by i_interrupt=1 in BOOT, RUN or IMM.
  - Sticky: held across stalls and branches.
  - i_interrupt is ignored while in INT.
  - Repeated or level requests while pending produce one service only.
- Arithmetic: pc+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000. An IMM instruction at 16'hFFFF takes its immediate from 16'h0000.

## Timing

- One-cycle latency: the word at o_imem_addr in cycle N appears on o_instr with o_valid=1 after edge N.
- Two-word instructions: one bubble (o_valid=0) followed by the complete bundle.
- Branch: the bundle after the redirect edge is a bubble; the target word appears one cycle later.
- Boot: the first valid bundle appears 2 edges after reset deassertion.
- Interrupt service:
  - Interrupt bundle at edge E.
  - Vector load at edge E+1.
  - First handler bundle at edge E+2.
- Reset asserted mid-operation, in any state, overrides everything at that edge.
- Stall: all registers, including state, hold_* and pending_int, are unchanged, and o_imem_addr is stable.

## Test plan

- Boot: mem[0]=16'h0020, mem[16'h20]=16'h2401; release reset.
  - Required: imem_addr 0, then 16'h0020.
  - Then o_instr=16'h2401, o_pc=16'h0020, o_valid=1 on the second edge.
- Immediate pair: mem[16'h21]=16'hC000, mem[16'h22]=16'h1234.
  - Required: one o_valid=0 cycle.
  - Then o_instr=16'hC000, o_imm=16'h1234, o_pc=16'h0021.
  - Next fetch address is 16'h0023.
- Branch during IMM: i_branch_taken=1, target 16'h0050, issued in the IMM cycle.
  - Required: 16'hC000 is never emitted valid.
  - o_valid=0 for one cycle, then o_pc=16'h0050.
- Stall: i_stall=1 for 3 cycles mid-stream.
  - Required: o_instr, o_pc, o_valid and o_imem_addr are constant.
  - Stream resumes with no word lost or duplicated.
- Interrupt: mem[1]=16'h0100; 1-cycle i_interrupt pulse while pc=16'h0025, or during IMM at 16'h0025/16'h0026.
  - Required: o_interrupt=1, o_valid=1, o_pc=16'h0025 (or 16'h0027 after the pair).
  - Then a bubble, then o_pc=16'h0100.
  - A second pulse during INT is ignored.
- Wrap and reset: pc=16'hFFFF holding a one-word instruction.
  - Required: next o_pc=16'h0000.
  - i_reset_n=0 during IMM returns to BOOT with all outputs zero at that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address,
// and hands decode one registered bundle per instruction (two-word immediate
// instructions are merged into a single bundle). Handles boot vector, branch
// redirects, stalls and interrupt vectoring.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   BOOT  | reading the boot vector word; next PC comes from imem
//   RUN   | normal fetch; one bundle per one-word instruction
//   IMM   | first word of a two-word instruction held; fetching its immediate
//   INT   | interrupt bundle issued; reading the handler vector word
module fetch_stage #(
    parameter logic [15:0] RESET_VECTOR_ADDR = 16'h0000,
    parameter logic [15:0] INT_VECTOR_ADDR   = 16'h0001,
    parameter logic [2:0]  IMM_OPCODE        = 3'b110
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    input  logic        i_interrupt,
    output logic [15:0] o_instr,
    output logic [15:0] o_imm,
    output logic [15:0] o_pc,
    output logic        o_valid,
    output logic        o_interrupt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_IMM  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        pending_int_q, pending_int_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic        valid_q, valid_d;
    logic        interrupt_q, interrupt_d;

    logic [15:0] pc_inc;
    logic        is_imm_word;

    assign pc_inc      = pc_q + 16'd1;
    assign is_imm_word = (i_imem_data[15:13] == IMM_OPCODE);

    // Fetch address depends only on registered state, so it is stable under stall.
    always_comb begin
        o_imem_addr = pc_q;
        case (state_q)
            ST_BOOT: o_imem_addr = RESET_VECTOR_ADDR;
            ST_INT:  o_imem_addr = INT_VECTOR_ADDR;
            default: o_imem_addr = pc_q;
        endcase
    end

    // Next-state and bundle computation; every register defaults to hold.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_int_d = pending_int_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        instr_d       = instr_q;
        imm_d         = imm_q;
        out_pc_d      = out_pc_q;
        valid_d       = valid_q;
        interrupt_d   = interrupt_q;

        case (state_q)
            ST_BOOT: begin
                pc_d          = i_imem_data;
                valid_d       = 1'b0;
                interrupt_d   = 1'b0;
                pending_int_d = pending_int_q | i_interrupt;
                state_d       = ST_RUN;
            end

            ST_RUN: begin
                if (i_branch_taken) begin
                    pc_d          = i_branch_target;
                    valid_d       = 1'b0;
                    interrupt_d   = 1'b0;
                    pending_int_d = pending_int_q | i_interrupt;
                end else if (i_stall) begin
                    // Full freeze: a request arriving only during a stall is not captured.
                end else if (pending_int_q) begin
                    // pc is the first unexecuted address and becomes the return address.
                    instr_d     = 16'h0000;
                    out_pc_d    = pc_q;
                    valid_d     = 1'b1;
                    interrupt_d = 1'b1;
                    state_d     = ST_INT;
                end else if (is_imm_word) begin
                    hold_instr_d  = i_imem_data;
                    hold_pc_d     = pc_q;
                    pc_d          = pc_inc;
                    valid_d       = 1'b0;
                    interrupt_d   = 1'b0;
                    pending_int_d = i_interrupt;
                    state_d       = ST_IMM;
                end else begin
                    instr_d       = i_imem_data;
                    imm_d         = 16'h0000;
                    out_pc_d      = pc_q;
                    valid_d       = 1'b1;
                    interrupt_d   = 1'b0;
                    pc_d          = pc_inc;
                    pending_int_d = i_interrupt;
                end
            end

            ST_IMM: begin
                if (i_branch_taken) begin
                    pc_d          = i_branch_target;
                    valid_d       = 1'b0;
                    interrupt_d   = 1'b0;
                    pending_int_d = pending_int_q | i_interrupt;
                    state_d       = ST_RUN;
                end else if (i_stall) begin
                    // Full freeze, same as RUN.
                end else begin
                    // Interrupts wait until the pair is delivered, never split it.
                    instr_d       = hold_instr_q;
                    imm_d         = i_imem_data;
                    out_pc_d      = hold_pc_q;
                    valid_d       = 1'b1;
                    interrupt_d   = 1'b0;
                    pc_d          = pc_inc;
                    pending_int_d = pending_int_q | i_interrupt;
                    state_d       = ST_RUN;
                end
            end

            ST_INT: begin
                pc_d          = i_imem_data;
                pending_int_d = 1'b0;
                valid_d       = 1'b0;
                interrupt_d   = 1'b0;
                state_d       = ST_RUN;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and bundle registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= 16'h0000;
            pending_int_q <= 1'b0;
            hold_instr_q  <= 16'h0000;
            hold_pc_q     <= 16'h0000;
            instr_q       <= 16'h0000;
            imm_q         <= 16'h0000;
            out_pc_q      <= 16'h0000;
            valid_q       <= 1'b0;
            interrupt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_int_q <= pending_int_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            instr_q       <= instr_d;
            imm_q         <= imm_d;
            out_pc_q      <= out_pc_d;
            valid_q       <= valid_d;
            interrupt_q   <= interrupt_d;
        end
    end

    assign o_instr     = instr_q;
    assign o_imm       = imm_q;
    assign o_pc        = out_pc_q;
    assign o_valid     = valid_q;
    assign o_interrupt = interrupt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scripted vector table plus hand-written
// sequences for stall, reset-during-IMM and immediate wrap-around.
module tb_fetch_stage;

    logic        i_clk;
    logic        i_reset_n;
    logic [15:0] o_imem_addr;
    logic [15:0] i_imem_data;
    logic        i_stall;
    logic        i_branch_taken;
    logic [15:0] i_branch_target;
    logic        i_interrupt;
    logic [15:0] o_instr;
    logic [15:0] o_imm;
    logic [15:0] o_pc;
    logic        o_valid;
    logic        o_interrupt;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .o_imem_addr     (o_imem_addr),
        .i_imem_data     (i_imem_data),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_interrupt     (i_interrupt),
        .o_instr         (o_instr),
        .o_imm           (o_imm),
        .o_pc            (o_pc),
        .o_valid         (o_valid),
        .o_interrupt     (o_interrupt)
    );

    assign i_imem_data = mem[o_imem_addr];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        irq;
        logic        chk_addr;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        valid;
        logic        intr;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst_n, input logic br, input logic [15:0] tgt,
                                input logic irq, input logic chk_addr, input logic [15:0] addr,
                                input logic [15:0] instr, input logic [15:0] imm,
                                input logic [15:0] pc, input logic valid, input logic intr);
        vec_t v;
        v.rst_n = rst_n; v.stall = 1'b0; v.br = br; v.tgt = tgt; v.irq = irq;
        v.chk_addr = chk_addr; v.addr = addr;
        v.instr = instr; v.imm = imm; v.pc = pc; v.valid = valid; v.intr = intr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic stall, input logic br,
                         input logic [15:0] tgt, input logic irq);
        i_reset_n       = rst_n;
        i_stall         = stall;
        i_branch_taken  = br;
        i_branch_target = tgt;
        i_interrupt     = irq;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_bundle(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                              input logic [15:0] pc, input logic valid, input logic intr);
        chk({tag, " instr"}, o_instr, instr);
        chk({tag, " imm"},   o_imm, imm);
        chk({tag, " pc"},    o_pc, pc);
        chk({tag, " valid"}, {15'd0, o_valid}, {15'd0, valid});
        chk({tag, " intr"},  {15'd0, o_interrupt}, {15'd0, intr});
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = {4'h0, a[11:0]};
        mem[16'h0000] = 16'h0020;
        mem[16'h0001] = 16'h0100;
        mem[16'h0020] = 16'h2401;
        mem[16'h0021] = 16'hC000;
        mem[16'h0022] = 16'h1234;
        mem[16'h0040] = 16'hC0AA;
        mem[16'h0041] = 16'h5555;
        mem[16'h0060] = 16'hC123;
        mem[16'h0061] = 16'h7777;

        //              rst br  tgt      irq ca addr      instr     imm       pc        v  int
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0000, 0, 1, 16'h0020, 16'h2401, 16'h0000, 16'h0020, 1, 0);
        vecs[3]  = mk(1, 0, 16'h0000, 0, 1, 16'h0021, 16'h2401, 16'h0000, 16'h0020, 0, 0);
        vecs[4]  = mk(1, 0, 16'h0000, 0, 1, 16'h0022, 16'hC000, 16'h1234, 16'h0021, 1, 0);
        vecs[5]  = mk(1, 0, 16'h0000, 0, 1, 16'h0023, 16'h0023, 16'h0000, 16'h0023, 1, 0);
        vecs[6]  = mk(1, 0, 16'h0000, 1, 1, 16'h0024, 16'h0024, 16'h0000, 16'h0024, 1, 0);
        vecs[7]  = mk(1, 0, 16'h0000, 0, 1, 16'h0025, 16'h0000, 16'h0000, 16'h0025, 1, 1);
        vecs[8]  = mk(1, 0, 16'h0000, 1, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0025, 0, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 0, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 1, 0);
        vecs[10] = mk(1, 0, 16'h0000, 0, 1, 16'h0101, 16'h0101, 16'h0000, 16'h0101, 1, 0);
        vecs[11] = mk(1, 1, 16'h0040, 0, 1, 16'h0102, 16'h0101, 16'h0000, 16'h0101, 0, 0);
        vecs[12] = mk(1, 0, 16'h0000, 1, 1, 16'h0040, 16'h0101, 16'h0000, 16'h0101, 0, 0);
        vecs[13] = mk(1, 0, 16'h0000, 0, 1, 16'h0041, 16'hC0AA, 16'h5555, 16'h0040, 1, 0);
        vecs[14] = mk(1, 0, 16'h0000, 0, 1, 16'h0042, 16'h0000, 16'h5555, 16'h0042, 1, 1);
        vecs[15] = mk(1, 0, 16'h0000, 0, 1, 16'h0001, 16'h0000, 16'h5555, 16'h0042, 0, 0);
        vecs[16] = mk(1, 0, 16'h0000, 0, 1, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 1, 0);
        vecs[17] = mk(1, 1, 16'h0060, 0, 1, 16'h0101, 16'h0100, 16'h0000, 16'h0100, 0, 0);
        vecs[18] = mk(1, 0, 16'h0000, 0, 1, 16'h0060, 16'h0100, 16'h0000, 16'h0100, 0, 0);
        vecs[19] = mk(1, 1, 16'h0050, 0, 1, 16'h0061, 16'h0100, 16'h0000, 16'h0100, 0, 0);
        vecs[20] = mk(1, 0, 16'h0000, 0, 1, 16'h0050, 16'h0050, 16'h0000, 16'h0050, 1, 0);
        vecs[21] = mk(1, 0, 16'h0000, 0, 1, 16'h0051, 16'h0051, 16'h0000, 16'h0051, 1, 0);
        vecs[22] = mk(1, 1, 16'hFFFF, 0, 1, 16'h0052, 16'h0051, 16'h0000, 16'h0051, 0, 0);
        vecs[23] = mk(1, 0, 16'h0000, 0, 1, 16'hFFFF, 16'h0FFF, 16'h0000, 16'hFFFF, 1, 0);
        vecs[24] = mk(1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 1, 0);

        drive(0, 0, 0, 16'h0000, 0);
        @(negedge i_clk);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].irq);
            #1;
            if (vecs[i].chk_addr) chk($sformatf("row%0d addr", i), o_imem_addr, vecs[i].addr);
            cyc();
            chk_bundle($sformatf("row%0d", i), vecs[i].instr, vecs[i].imm, vecs[i].pc,
                       vecs[i].valid, vecs[i].intr);
        end

        // Stall for three cycles at pc=1: bundle and fetch address frozen.
        drive(1, 1, 0, 16'h0000, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d addr_pre", k), o_imem_addr, 16'h0001);
            cyc();
            chk_bundle($sformatf("stall%0d", k), 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b0);
            chk($sformatf("stall%0d addr", k), o_imem_addr, 16'h0001);
        end
        drive(1, 0, 0, 16'h0000, 0);
        cyc();
        chk_bundle("resume0", 16'h0100, 16'h0000, 16'h0001, 1'b1, 1'b0);
        cyc();
        chk_bundle("resume1", 16'h0002, 16'h0000, 16'h0002, 1'b1, 1'b0);

        // Reset asserted while in IMM.
        drive(1, 0, 1, 16'h0040, 0);
        cyc();
        chk("rst_seq br valid", {15'd0, o_valid}, 16'h0000);
        drive(1, 0, 0, 16'h0000, 0);
        cyc();
        chk("rst_seq imm addr", o_imem_addr, 16'h0041);
        chk("rst_seq imm valid", {15'd0, o_valid}, 16'h0000);
        chk("rst_seq pre instr", o_instr, 16'h0002);
        drive(0, 0, 0, 16'h0000, 0);
        cyc();
        chk_bundle("rst_mid", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("rst_mid addr", o_imem_addr, 16'h0000);
        drive(1, 0, 0, 16'h0000, 0);
        cyc();
        chk("reboot addr", o_imem_addr, 16'h0020);
        chk("reboot valid", {15'd0, o_valid}, 16'h0000);
        cyc();
        chk_bundle("reboot first", 16'h2401, 16'h0000, 16'h0020, 1'b1, 1'b0);

        // Two-word instruction at 0xFFFF takes its immediate from 0x0000.
        mem[16'hFFFF] = 16'hC0FF;
        drive(1, 0, 1, 16'hFFFF, 0);
        cyc();
        drive(1, 0, 0, 16'h0000, 0);
        #1;
        chk("wrapimm addr0", o_imem_addr, 16'hFFFF);
        cyc();
        chk("wrapimm addr1", o_imem_addr, 16'h0000);
        chk("wrapimm bubble", {15'd0, o_valid}, 16'h0000);
        cyc();
        chk_bundle("wrapimm pair", 16'hC0FF, 16'h0020, 16'hFFFF, 1'b1, 1'b0);
        chk("wrapimm next addr", o_imem_addr, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
